// File: rtl/nibble_mult_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_mult_sequencer_if
// Purpose  : Operand, shared-core and result handshake bundle for the sequencer.
// Revision : 1.0
// ============================================================================
interface nibble_mult_sequencer_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [3:0]           mul_a;
    logic [3:0]           mul_b;
    logic                 mul_en;
    logic [7:0]           mul_p;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_prod;
    logic                 busy;

    modport slave (
        input  in_valid, in_a, in_b, mul_p, out_ready,
        output in_ready, mul_a, mul_b, mul_en, out_valid, out_prod, busy
    );

    modport master (
        output in_valid, in_a, in_b, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, mul_en, out_valid, out_prod, busy
    );
endinterface
`default_nettype wire

// File: rtl/nibble_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nibble_mult_sequencer
// Purpose  : WIDTH x WIDTH multiply, one nibble pair per cycle on a shared 4x4 core.
// Revision : 1.0
// ============================================================================
module nibble_mult_sequencer #(
    parameter int WIDTH    = 8,
    parameter int SKIP_LOW = 0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    nibble_mult_sequencer_if.slave  bus
);
    localparam int c_NIB = WIDTH / 4;
    localparam int c_IW  = (c_NIB > 1) ? $clog2(c_NIB) : 1;
    localparam int c_PW  = 2 * WIDTH;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(c_NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_IW-1:0]   i_q, i_d;
    logic [c_IW-1:0]   j_q, j_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [c_PW-1:0]   acc_q, acc_d;

    logic [3:0]        w_nib_a;
    logic [3:0]        w_nib_b;
    logic [c_IW:0]     w_ij;
    logic              w_skip;
    logic [c_PW-1:0]   w_pp;

    // Step counter is kept as (i, j) so no divider is needed for non power-of-two NIB.
    always_comb begin
        w_nib_a = '0;
        w_nib_b = '0;
        for (int n = 0; n < c_NIB; n++) begin
            if (i_q == c_IW'(n)) w_nib_a = a_q[4*n +: 4];
            if (j_q == c_IW'(n)) w_nib_b = b_q[4*n +: 4];
        end
    end

    assign w_ij   = {1'b0, i_q} + {1'b0, j_q};
    assign w_skip = int'(w_ij) < SKIP_LOW;
    assign w_pp   = {{(c_PW-8){1'b0}}, bus.mul_p} << {w_ij, 2'b00};

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        bus.in_ready  = (state_q == S_IDLE);
        bus.busy      = (state_q != S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.out_prod  = (state_q == S_DONE) ? acc_q : '0;
        bus.mul_en    = 1'b0;
        bus.mul_a     = 4'h0;
        bus.mul_b     = 4'h0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_skip) begin
                    bus.mul_en = 1'b1;
                    bus.mul_a  = w_nib_a;
                    bus.mul_b  = w_nib_b;
                    acc_d      = acc_q + w_pp;
                end
                if (i_q == c_LAST) begin
                    i_d = '0;
                    if (j_q == c_LAST) begin
                        j_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        j_d = j_q + c_IW'(1);
                    end
                end else begin
                    i_d = i_q + c_IW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nibble_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_mult_sequencer
// Purpose  : Self-checking bench; exact, truncated and 16-bit sequencers vs a model.
// Revision : 1.0
// ============================================================================
module tb_nibble_mult_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    nibble_mult_sequencer_if #(.WIDTH(8))  if_e ();
    nibble_mult_sequencer_if #(.WIDTH(8))  if_s ();
    nibble_mult_sequencer_if #(.WIDTH(16)) if_w ();

    assign if_e.mul_p = if_e.mul_a * if_e.mul_b;
    assign if_s.mul_p = if_s.mul_a * if_s.mul_b;
    assign if_w.mul_p = if_w.mul_a * if_w.mul_b;

    nibble_mult_sequencer #(.WIDTH(8),  .SKIP_LOW(0)) u_exact (.clk(clk), .rst_n(rst_n), .bus(if_e.slave));
    nibble_mult_sequencer #(.WIDTH(8),  .SKIP_LOW(1)) u_skip  (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
    nibble_mult_sequencer #(.WIDTH(16), .SKIP_LOW(0)) u_wide  (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));

    // Reference for truncated products: sum of nibble products with weight >= skip.
    function automatic logic [31:0] ref_prod(logic [15:0] a, logic [15:0] b, int nib, int skip);
        logic [31:0] p = 32'h0;
        logic [31:0] t;
        for (int i = 0; i < nib; i++)
            for (int j = 0; j < nib; j++)
                if (i + j >= skip) begin
                    t = ((32'(a) >> (4*i)) & 32'hF) * ((32'(b) >> (4*j)) & 32'hF);
                    p = p + (t << (4*(i+j)));
                end
        return p;
    endfunction

    function automatic logic ov_of(int sel);
        case (sel)
            0:       return if_e.out_valid;
            1:       return if_s.out_valid;
            default: return if_w.out_valid;
        endcase
    endfunction

    function automatic logic [31:0] prod_of(int sel);
        case (sel)
            0:       return {16'h0, if_e.out_prod};
            1:       return {16'h0, if_s.out_prod};
            default: return if_w.out_prod;
        endcase
    endfunction

    // Runs one operation end to end; returns edges from accept to out_valid and the result.
    task automatic op(input int sel, input logic [15:0] a, input logic [15:0] b,
                      input bit early, output int lat, output logic [31:0] prod);
        case (sel)
            0: begin if_e.in_a = a[7:0]; if_e.in_b = b[7:0]; if_e.out_ready = early; if_e.in_valid = 1'b1; end
            1: begin if_s.in_a = a[7:0]; if_s.in_b = b[7:0]; if_s.out_ready = early; if_s.in_valid = 1'b1; end
            default: begin if_w.in_a = a; if_w.in_b = b; if_w.out_ready = early; if_w.in_valid = 1'b1; end
        endcase
        @(posedge clk); #1;
        if_e.in_valid = 1'b0; if_s.in_valid = 1'b0; if_w.in_valid = 1'b0;
        lat = 0;
        while (!ov_of(sel) && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = prod_of(sel);
        if_e.out_ready = 1'b1; if_s.out_ready = 1'b1; if_w.out_ready = 1'b1;
        @(posedge clk); #1;
        if_e.out_ready = 1'b0; if_s.out_ready = 1'b0; if_w.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({if_e.in_ready, if_e.out_valid, if_e.busy, if_e.mul_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset flags {in_ready,out_valid,busy,mul_en}: got %b want 1000",
                     {if_e.in_ready, if_e.out_valid, if_e.busy, if_e.mul_en});
        end
        n_checks++;
        if (if_e.out_prod !== 16'h0) begin
            n_fail++;
            $display("FAIL reset out_prod: got %h want 0000", if_e.out_prod);
        end
        n_checks++;
        if ({if_e.mul_a, if_e.mul_b} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset mul_a/mul_b: got %h want 00", {if_e.mul_a, if_e.mul_b});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_exact();
        logic [7:0]  ta[6] = '{8'hFF, 8'h0F, 8'h00, 8'h80, 8'hA7, 8'h01};
        logic [7:0]  tb[6] = '{8'hFF, 8'h10, 8'hAB, 8'h02, 8'h5C, 8'hFF};
        logic [15:0] e;
        logic [31:0] got, exp;
        int lat;
        for (int k = 0; k < 6; k++) begin
            e = ta[k] * tb[k];
            sb.push_back({16'h0, e});
            op(0, {8'h0, ta[k]}, {8'h0, tb[k]}, k[0], lat, got);
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL exact[%0d] prod: got %h want %h", k, got, exp);
            end
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL exact[%0d] latency: got %0d want 4", k, lat);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        int lat;
        sb.push_back(32'(8'hA5 * 8'h3C));
        exp = sb.pop_front();
        if_e.in_a = 8'hA5; if_e.in_b = 8'h3C; if_e.in_valid = 1'b1;
        @(posedge clk); #1;
        if_e.in_valid = 1'b0;
        lat = 0;
        while (!if_e.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int c = 0; c < 3; c++) begin
            if_e.in_valid = 1'b1;
            if_e.in_a = 8'($urandom);
            if_e.in_b = 8'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if ({if_e.out_valid, if_e.in_ready, if_e.busy} !== 3'b101 || {16'h0, if_e.out_prod} !== exp) begin
                n_fail++;
                $display("FAIL stall[%0d] {ov,ir,busy}/prod: got %b/%h want 101/%h",
                         c, {if_e.out_valid, if_e.in_ready, if_e.busy}, if_e.out_prod, exp);
            end
        end
        if_e.in_valid = 1'b0;
        if_e.out_ready = 1'b1;
        @(posedge clk); #1;
        if_e.out_ready = 1'b0;
        n_checks++;
        if ({if_e.out_valid, if_e.in_ready, if_e.busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL stall release {ov,ir,busy}: got %b want 010",
                     {if_e.out_valid, if_e.in_ready, if_e.busy});
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] got, exp;
        int lat;
        if_e.in_a = 8'h77; if_e.in_b = 8'h99; if_e.in_valid = 1'b1;
        @(posedge clk); #1;
        if_e.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if ({if_e.busy, if_e.mul_en, if_e.mul_a, if_e.mul_b} !== {2'b11, 8'h79}) begin
            n_fail++;
            $display("FAIL midrun step2 {busy,en,a,b}: got %h want 379",
                     {if_e.busy, if_e.mul_en, if_e.mul_a, if_e.mul_b});
        end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({if_e.in_ready, if_e.out_valid, if_e.busy, if_e.mul_en, if_e.mul_a, if_e.mul_b, if_e.out_prod}
            !== {4'b1000, 8'h00, 16'h0000}) begin
            n_fail++;
            $display("FAIL midrun reset outputs: got %b/%h/%h want 1000/00/0000",
                     {if_e.in_ready, if_e.out_valid, if_e.busy, if_e.mul_en},
                     {if_e.mul_a, if_e.mul_b}, if_e.out_prod);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.push_back(32'(8'h12 * 8'h34));
        op(0, 16'h12, 16'h34, 1'b0, lat, got);
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp || lat !== 4) begin
            n_fail++;
            $display("FAIL post-reset op prod/lat: got %h/%0d want %h/4", got, lat, exp);
        end
    endtask

    task automatic test_skip_low();
        logic [31:0] got, exp;
        int lat;
        sb.push_back(ref_prod(16'h1F, 16'h11, 2, 1));
        if_s.in_a = 8'h1F; if_s.in_b = 8'h11; if_s.in_valid = 1'b1;
        @(posedge clk); #1;
        if_s.in_valid = 1'b0;
        n_checks++;
        if ({if_s.mul_en, if_s.mul_a, if_s.mul_b} !== 9'h000) begin
            n_fail++;
            $display("FAIL skip step0 {en,a,b}: got %h want 000", {if_s.mul_en, if_s.mul_a, if_s.mul_b});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({if_s.mul_en, if_s.mul_a, if_s.mul_b} !== 9'h111) begin
            n_fail++;
            $display("FAIL skip step1 {en,a,b}: got %h want 111", {if_s.mul_en, if_s.mul_a, if_s.mul_b});
        end
        lat = 1;
        while (!if_s.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {16'h0, if_s.out_prod};
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp || exp !== 32'h0200 || lat !== 4) begin
            n_fail++;
            $display("FAIL skip 1Fx11 prod/lat: got %h/%0d want %h/4", got, lat, exp);
        end
        if_s.out_ready = 1'b1;
        @(posedge clk); #1;
        if_s.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic [15:0] a, b;
            a = (k == 0) ? 16'h0F : 16'($urandom_range(0, 255));
            b = (k == 0) ? 16'h0F : 16'($urandom_range(0, 255));
            sb.push_back(ref_prod(a, b, 2, 1));
            op(1, a, b, 1'b0, lat, got);
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp || lat !== 4) begin
                n_fail++;
                $display("FAIL skip[%0d] %h*%h prod/lat: got %h/%0d want %h/4", k, a, b, got, lat, exp);
            end
        end
    endtask

    task automatic test_wide_random();
        logic [15:0] a, b;
        logic [31:0] e, got, exp;
        int lat;
        for (int k = 0; k < 500; k++) begin
            a = (k == 0) ? 16'hFFFF : (k == 1) ? 16'h0000 : 16'($urandom);
            b = (k == 0) ? 16'hFFFF : 16'($urandom);
            e = a * b;
            sb.push_back(e);
            op(2, a, b, k[2], lat, got);
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wide[%0d] %h*%h prod: got %h want %h", k, a, b, got, exp);
            end
            n_checks++;
            if (lat !== 16) begin
                n_fail++;
                $display("FAIL wide[%0d] latency: got %0d want 16", k, lat);
            end
        end
    endtask

    initial begin
        if_e.in_valid = 1'b0; if_e.in_a = '0; if_e.in_b = '0; if_e.out_ready = 1'b0;
        if_s.in_valid = 1'b0; if_s.in_a = '0; if_s.in_b = '0; if_s.out_ready = 1'b0;
        if_w.in_valid = 1'b0; if_w.in_a = '0; if_w.in_b = '0; if_w.out_ready = 1'b0;
        test_reset();
        test_exact();
        test_stall();
        test_reset_midrun();
        test_skip_low();
        test_wide_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
